// File: rtl/pe_8x2_hybrid_pkg.sv
// pe_pkg: shared defaults and arithmetic helpers for the 8x2 hybrid readout PE.
//   W_ACC / W_DATA / N_IN : default widths and vector length
//   sum0_t / sum1_t       : full-precision signed column sums (col0 / col1)
//   sat_to_acc()          : clamp a full-precision sum into W_ACC bits
// Saturation is used only when PE_SAT_EN is defined (see pe_dot_col).
package pe_pkg;

    localparam int W_ACC  = 32;
    localparam int W_DATA = 16;
    localparam int N_IN   = 8;

    localparam int LOG2_N  = $clog2(N_IN);
    localparam int W_SUM0  = 2 * W_DATA + LOG2_N;        // 35
    localparam int W_SUM1  = W_DATA + W_ACC + LOG2_N;    // 51
    localparam int SUM_MAX = W_SUM1;

    typedef logic signed [W_SUM0-1:0] sum0_t;
    typedef logic signed [W_SUM1-1:0] sum1_t;
    typedef logic signed [W_ACC-1:0]  acc_t;

    localparam sum1_t ACC_MAX = {{(SUM_MAX-W_ACC+1){1'b0}}, {(W_ACC-1){1'b1}}};
    localparam sum1_t ACC_MIN = {{(SUM_MAX-W_ACC+1){1'b1}}, {(W_ACC-1){1'b0}}};

    // Exact at both bounds; anything beyond is pinned, never wrapped.
    function automatic acc_t sat_to_acc(input sum1_t s);
        if (s > ACC_MAX)
            return {1'b0, {(W_ACC-1){1'b1}}};
        else if (s < ACC_MIN)
            return {1'b1, {(W_ACC-1){1'b0}}};
        else
            return s[W_ACC-1:0];
    endfunction

endpackage

// File: rtl/pe_8x2_hybrid_if.sv
// pe_8x2_hybrid_if: data bus of the 8x2 hybrid PE.
//   ce     : clock enable for the whole pipeline
//   DATA   : N_IN x W_DATA signed reservoir states
//   WEIGHT : col0 weights (N_IN x W_DATA) in the low part, col1 weights (N_IN x W_ACC) above
//   Q      : N_OUT x W_ACC signed column results
// master drives ce/DATA/WEIGHT and reads Q; slave is the PE side.
interface pe_8x2_hybrid_if #(
    parameter int W_ACC  = pe_pkg::W_ACC,
    parameter int W_DATA = pe_pkg::W_DATA,
    parameter int N_IN   = pe_pkg::N_IN,
    parameter int N_OUT  = 2
);
    logic                               ce;
    logic [N_IN*W_DATA-1:0]             DATA;
    logic [N_IN*W_ACC+N_IN*W_DATA-1:0]  WEIGHT;
    logic [N_OUT*W_ACC-1:0]             Q;

    modport master (output ce, output DATA, output WEIGHT, input Q);
    modport slave  (input ce, input DATA, input WEIGHT, output Q);
endinterface

// File: rtl/pe_8x2_hybrid_dot_col.sv
// pe_dot_col: one signed dot-product column of the PE.
//   clk, rst : clock, synchronous active-high reset (priority over ce)
//   ce       : clock enable, 0 holds every stage
//   data     : N_IN x W_DATA signed inputs
//   wgt      : N_IN x W_WGT signed weights
//   q        : W_ACC result, 3 enabled clocks after data/wgt are sampled
// Pipeline: products -> balanced adder tree sum -> output register.
// Macro PE_SAT_EN: defined -> q saturates to W_ACC; undefined -> q wraps.
module pe_dot_col #(
    parameter int W_DATA = pe_pkg::W_DATA,
    parameter int W_WGT  = pe_pkg::W_DATA,
    parameter int W_ACC  = pe_pkg::W_ACC,
    parameter int N_IN   = pe_pkg::N_IN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [N_IN*W_DATA-1:0]  data,
    input  logic [N_IN*W_WGT-1:0]   wgt,
    output logic [W_ACC-1:0]        q
);
    import pe_pkg::*;

`ifdef PE_SAT_EN
    localparam int PW = W_DATA + W_WGT;
    localparam int SW = PW + $clog2(N_IN);
`else
    // Only the low W_ACC bits survive a wrapping output, and they are the same
    // whatever width the sum is built at, so products and tree stay W_ACC wide.
    localparam int PW = (W_DATA + W_WGT < W_ACC) ? (W_DATA + W_WGT) : W_ACC;
    localparam int SW = W_ACC;
`endif

    if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n
        $error("pe_dot_col: N_IN must be a power of two >= 2");
    end
`ifdef PE_SAT_EN
    if (SW > SUM_MAX || W_ACC != pe_pkg::W_ACC) begin : g_bad_w
        $error("pe_dot_col: widths exceed the saturation helper");
    end
`endif

    logic signed [PW-1:0] dx   [N_IN];
    logic signed [PW-1:0] wx   [N_IN];
    logic signed [PW-1:0] prod [N_IN];
    // Heap-ordered tree: leaves at [N_IN-1 .. 2*N_IN-2], root at [0].
    logic signed [SW-1:0] tree [2*N_IN-1];
    logic signed [SW-1:0] sum;

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            dx[i]           = PW'($signed(data[i*W_DATA +: W_DATA]));
            wx[i]           = PW'($signed(wgt[i*W_WGT +: W_WGT]));
            tree[N_IN-1+i]  = SW'(prod[i]);
        end
        for (int unsigned j = 0; j < N_IN - 1; j++) begin
            tree[N_IN-2-j] = tree[2*(N_IN-2-j)+1] + tree[2*(N_IN-2-j)+2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_IN; i++) prod[i] <= '0;
            sum <= '0;
            q   <= '0;
        end else if (ce) begin
            for (int unsigned i = 0; i < N_IN; i++) prod[i] <= dx[i] * wx[i];
            sum <= tree[0];
`ifdef PE_SAT_EN
            q   <= sat_to_acc(sum1_t'(sum));
`else
            q   <= sum;
`endif
        end
    end

endmodule

// File: rtl/pe_8x2_hybrid.sv
// pe_8x2_hybrid: readout PE, two signed dot products over one shared vector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pe_8x2_hybrid_if.slave (ce, DATA, WEIGHT in; Q out)
// Column 0 uses W_DATA-bit weights, column 1 W_ACC-bit weights.
// Latency 3 enabled clocks, one vector per enabled clock.
// Macro PE_SAT_EN selects saturating (defined) or wrapping (undefined) outputs.
module pe_8x2_hybrid #(
    parameter int W_ACC  = pe_pkg::W_ACC,
    parameter int W_DATA = pe_pkg::W_DATA,
    parameter int N_IN   = pe_pkg::N_IN,
    parameter int N_OUT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_8x2_hybrid_if.slave       bus
);
    if (N_OUT != 2) begin : g_bad_nout
        $error("pe_8x2_hybrid: N_OUT is fixed at 2");
    end

    logic [W_ACC-1:0] q0;
    logic [W_ACC-1:0] q1;

    pe_dot_col #(
        .W_DATA (W_DATA),
        .W_WGT  (W_DATA),
        .W_ACC  (W_ACC),
        .N_IN   (N_IN)
    ) u_col0 (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .data (bus.DATA),
        .wgt  (bus.WEIGHT[N_IN*W_DATA-1:0]),
        .q    (q0)
    );

    pe_dot_col #(
        .W_DATA (W_DATA),
        .W_WGT  (W_ACC),
        .W_ACC  (W_ACC),
        .N_IN   (N_IN)
    ) u_col1 (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .data (bus.DATA),
        .wgt  (bus.WEIGHT[N_IN*W_DATA +: N_IN*W_ACC]),
        .q    (q1)
    );

    assign bus.Q = {q1, q0};

endmodule

// File: tb/tb_pe_8x2_hybrid.sv
// Testbench for pe_8x2_hybrid: directed vectors plus random streaming,
// checked against an integer dot-product model with a 3-deep latency queue.
// Expectations follow PE_SAT_EN (saturate when defined, wrap otherwise).
module tb_pe_8x2_hybrid;

    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -ACC_MAX - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [63:0]  pend[$];
    logic [63:0]  expq;
    logic [127:0] dv;
    logic [383:0] wv;
    logic [15:0]  v1d [8];
    logic [31:0]  v1w [8];

    pe_8x2_hybrid_if #(.W_ACC(32), .W_DATA(16), .N_IN(8), .N_OUT(2)) bif ();

    pe_8x2_hybrid #(.W_ACC(32), .W_DATA(16), .N_IN(8), .N_OUT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_col(input int col, input logic [127:0] d,
                                            input logic [383:0] w);
        longint acc;
        longint a;
        longint b;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            a = longint'($signed(d[i*16 +: 16]));
            if (col == 0) b = longint'($signed(w[i*16 +: 16]));
            else          b = longint'($signed(w[128 + i*32 +: 32]));
            acc += a * b;
        end
`ifdef PE_SAT_EN
        if (acc > ACC_MAX) return 32'h7FFFFFFF;
        if (acc < ACC_MIN) return 32'h80000000;
`endif
        return acc[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: advance the model with the inputs about to be sampled, then check Q.
    task automatic step(input string tag);
        if (rst) begin
            pend.delete();
            pend.push_back('0);
            pend.push_back('0);
            expq = '0;
        end else if (bif.ce) begin
            expq = pend.pop_front();
            pend.push_back({ref_col(1, bif.DATA, bif.WEIGHT), ref_col(0, bif.DATA, bif.WEIGHT)});
        end
        @(posedge clk);
        #1;
        check({tag, "/q0"}, bif.Q[31:0], expq[31:0]);
        check({tag, "/q1"}, bif.Q[63:32], expq[63:32]);
    endtask

    task automatic rand_vec(output logic [127:0] d, output logic [383:0] w);
        int unsigned mode;
        int t;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0: begin
                    d[i*16 +: 16]       = 16'($urandom);
                    w[i*16 +: 16]       = 16'($urandom);
                    w[128 + i*32 +: 32] = $urandom;
                end
                1: begin
                    t = int'($urandom_range(0, 511)) - 256; d[i*16 +: 16] = 16'(t);
                    t = int'($urandom_range(0, 511)) - 256; w[i*16 +: 16] = 16'(t);
                    t = int'($urandom_range(0, 511)) - 256; w[128 + i*32 +: 32] = 32'(t);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: d[i*16 +: 16] = 16'h8000;
                        1: d[i*16 +: 16] = 16'h7FFF;
                        2: d[i*16 +: 16] = 16'hFFFF;
                        default: d[i*16 +: 16] = 16'h0001;
                    endcase
                    w[i*16 +: 16] = $urandom_range(0, 1) != 0 ? 16'h8000 : 16'h7FFF;
                    w[128 + i*32 +: 32] = $urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h7FFFFFFF;
                end
            endcase
        end
    endtask

    task automatic drive(input logic [127:0] d, input logic [383:0] w);
        bif.DATA   = d;
        bif.WEIGHT = w;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        v1d = '{16'h0000, 16'h0001, 16'd10, 16'hFFFF, 16'hFFFF, 16'hF00E, 16'h0092, 16'h0201};
        v1w = '{32'h1, 32'h539B, 32'h8000, 32'h7FFF, 32'hFFFF, 32'h1, 32'h2B9C, 32'hA804};

        // Reset with ce low: reset must win regardless of ce.
        rst = 1'b1;
        bif.ce = 1'b0;
        drive('0, '0);
        step("reset_ce0");
        step("reset_ce0b");
        rst = 1'b0;
        bif.ce = 1'b1;

        // 1. Directed vector, result after 3 enabled clocks.
        for (int i = 0; i < 8; i++) begin
            dv[i*16 +: 16]       = v1d[i];
            wv[i*16 +: 16]       = v1d[i];
            wv[128 + i*32 +: 32] = v1w[i];
        end
        drive(dv, wv);
        step("vec_c1");
        drive('0, '0);
        step("vec_c2");
        step("vec_c3");
        check("vec_q0_const", bif.Q[31:0], 32'h01029870);
        check("vec_q1_const", bif.Q[63:32], 32'h016D52A7);

        // 2. Reset mid-stream discards the in-flight vector.
        drive(dv, wv);
        step("rst_load");
        rst = 1'b1;
        drive('0, '0);
        step("rst_edge");
        check("rst_q_zero", bif.Q[31:0], 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step("rst_after");

        // 3. ce hold with the vector two stages in.
        drive(dv, wv);
        step("hold_load");
        rand_vec(dv, wv);
        drive(dv, wv);
        step("hold_mid");
        bif.ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_vec(dv, wv);
            drive(dv, wv);
            step("hold_ce0");
        end
        bif.ce = 1'b1;
        drive('0, '0);
        step("hold_resume");
        check("hold_q0_const", bif.Q[31:0], 32'h01029870);
        check("hold_q1_const", bif.Q[63:32], 32'h016D52A7);

        // 4. Positive saturation on col0.
        rand_vec(dv, wv);
        for (int i = 0; i < 8; i++) begin
            dv[i*16 +: 16] = 16'h8000;
            wv[i*16 +: 16] = 16'h8000;
        end
        drive(dv, wv);
        step("sat_c1");
        drive('0, '0);
        step("sat_c2");
        step("sat_c3");
`ifdef PE_SAT_EN
        check("sat_q0_const", bif.Q[31:0], 32'h7FFFFFFF);
`else
        check("sat_q0_const", bif.Q[31:0], 32'h00000000);
`endif

        // 5. Negative clamp on col1.
        rand_vec(dv, wv);
        for (int i = 0; i < 8; i++) begin
            dv[i*16 +: 16]       = 16'h7FFF;
            wv[128 + i*32 +: 32] = 32'h80000000;
        end
        drive(dv, wv);
        step("neg_c1");
        drive('0, '0);
        step("neg_c2");
        step("neg_c3");
`ifdef PE_SAT_EN
        check("neg_q1_const", bif.Q[63:32], 32'h80000000);
`else
        check("neg_q1_const", bif.Q[63:32], 32'h00000000);
`endif

        // 6. Streaming, a new vector every clock.
        for (int k = 0; k < 200; k++) begin
            rand_vec(dv, wv);
            drive(dv, wv);
            step("stream");
        end

        // Random ce gaps and occasional resets over a stream.
        for (int k = 0; k < 150; k++) begin
            rand_vec(dv, wv);
            drive(dv, wv);
            bif.ce = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 49) == 0);
            step("stream_ce");
        end
        rst = 1'b0;
        bif.ce = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
